mem_port_arbiter: RTL and testbench

Shares the single memory port between the fetch stage (I side) and the memory stage (D side) of the five-stage pipeline. The block accepts one request at a time, latches it, and holds it on the downstream port until memory acknowledges. It then returns a one-cycle response to the owning requester. D has priority by default, and an optional starvation guard keeps fetch from being locked out during long load/store bursts.

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (I) and memory-stage (D) requests.
// Define MEM_ARB_STARVE_GUARD_EN to build the fetch starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_resp_valid,
  output logic [31:0]       i_resp_data,
  input  logic              i_flush,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_write,
  input  logic [2:0]        d_size,
  input  logic [7:0]        d_strobe,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_write,
  output logic [2:0]        m_size,
  output logic [7:0]        m_strobe,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_i_q, owner_i_d;
  logic                suppress_q, suppress_d;
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic                m_write_q, m_write_d;
  logic [2:0]          m_size_q, m_size_d;
  logic [7:0]          m_strobe_q, m_strobe_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic grant_i, grant_d, force_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_i = (starve_q == CNT_W'(STARVE_LIMIT));

  // Counts D wins that left a fetch waiting; saturates so I is forced at most once per run.
  always_comb begin
    starve_d = starve_q;
    if (grant_i) begin
      starve_d = '0;
    end else if (grant_d && i_valid && !force_i) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_i = (STARVE_LIMIT < 0);
`endif

  always_comb begin
    state_d    = state_q;
    owner_i_d  = owner_i_q;
    suppress_d = suppress_q;
    m_valid_d  = m_valid_q;
    m_addr_d   = m_addr_q;
    m_write_d  = m_write_q;
    m_size_d   = m_size_q;
    m_strobe_d = m_strobe_q;
    m_wdata_d  = m_wdata_q;
    data_d     = data_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // A forced I grant only happens if fetch is actually still asking.
        grant_i = i_valid && (force_i || !d_valid);
        grant_d = d_valid && !grant_i;
        if (grant_i) begin
          owner_i_d  = 1'b1;
          suppress_d = 1'b0;
          m_valid_d  = 1'b1;
          m_addr_d   = i_addr;
          m_write_d  = 1'b0;
          m_size_d   = 3'b010;
          m_strobe_d = 8'h00;
          m_wdata_d  = '0;
          state_d    = WAIT;
        end else if (grant_d) begin
          owner_i_d  = 1'b0;
          suppress_d = 1'b0;
          m_valid_d  = 1'b1;
          m_addr_d   = d_addr;
          m_write_d  = d_write;
          m_size_d   = d_size;
          m_strobe_d = d_strobe;
          m_wdata_d  = d_wdata;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (owner_i_q && i_flush) begin
          suppress_d = 1'b1;
        end
        if (m_ack) begin
          m_valid_d = 1'b0;
          data_d    = (!owner_i_q && m_write_q) ? '0 : m_rdata;
          state_d   = RESP;
        end
      end
      RESP: begin
        suppress_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_i_q  <= 1'b0;
      suppress_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_write_q  <= 1'b0;
      m_size_q   <= 3'b000;
      m_strobe_q <= 8'h00;
      m_wdata_q  <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_i_q  <= owner_i_d;
      suppress_q <= suppress_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      m_write_q  <= m_write_d;
      m_size_q   <= m_size_d;
      m_strobe_q <= m_strobe_d;
      m_wdata_q  <= m_wdata_d;
      data_q     <= data_d;
    end
  end

  assign i_ready = grant_i;
  assign d_ready = grant_d;

  assign m_valid  = m_valid_q;
  assign m_addr   = m_addr_q;
  assign m_write  = m_write_q;
  assign m_size   = m_size_q;
  assign m_strobe = m_strobe_q;
  assign m_wdata  = m_wdata_q;

  // A flush seen in the RESP cycle itself also kills the fetch response.
  assign i_resp_valid = (state_q == RESP) && owner_i_q && !suppress_q && !i_flush;
  assign d_resp_valid = (state_q == RESP) && !owner_i_q;
  assign i_resp_data  = i_resp_valid ? data_q[31:0] : 32'h0;
  assign d_resp_data  = d_resp_valid ? data_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter.
// Guard expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD_ON = 1'b1;
`else
   localparam bit GUARD_ON = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        iValid;
   logic [63:0] iAddr;
   logic        iReady;
   logic        iRespValid;
   logic [31:0] iRespData;
   logic        iFlush;
   logic        dValid;
   logic [63:0] dAddr;
   logic        dWrite;
   logic [2:0]  dSize;
   logic [7:0]  dStrobe;
   logic [63:0] dWdata;
   logic        dReady;
   logic        dRespValid;
   logic [63:0] dRespData;
   logic        mValid;
   logic [63:0] mAddr;
   logic        mWrite;
   logic [2:0]  mSize;
   logic [7:0]  mStrobe;
   logic [63:0] mWdata;
   logic        mAck;
   logic [63:0] mRdata;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic        isD;
      logic [63:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] wdata;
      int          k;
      logic [63:0] rdata;
      logic [2:0]  expSize;
      logic        expWrite;
      logic [7:0]  expStrobe;
      logic [63:0] expWdata;
      logic [63:0] expResp;
   } vec_t;

   vec_t vecs[5];

   mem_port_arbiter dut (
      .clk          (clock),
      .reset        (reset),
      .i_valid      (iValid),
      .i_addr       (iAddr),
      .i_ready      (iReady),
      .i_resp_valid (iRespValid),
      .i_resp_data  (iRespData),
      .i_flush      (iFlush),
      .d_valid      (dValid),
      .d_addr       (dAddr),
      .d_write      (dWrite),
      .d_size       (dSize),
      .d_strobe     (dStrobe),
      .d_wdata      (dWdata),
      .d_ready      (dReady),
      .d_resp_valid (dRespValid),
      .d_resp_data  (dRespData),
      .m_valid      (mValid),
      .m_addr       (mAddr),
      .m_write      (mWrite),
      .m_size       (mSize),
      .m_strobe     (mStrobe),
      .m_wdata      (mWdata),
      .m_ack        (mAck),
      .m_rdata      (mRdata)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clock = ~clock;

   // Absolute time limit so a wedged design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
      compared++;
      if (actual !== required) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One full transaction from the table: grant, hold, ack after k waits, response, back to idle.
   task automatic applyStimulus(input vec_t v, input int idx);
      tick();
      dAddr   = v.addr ^ 64'h0F0;
      dWrite  = v.write;
      dSize   = v.size;
      dStrobe = v.strobe;
      dWdata  = v.wdata;
      if (v.isD) begin
         dValid = 1'b1;
         dAddr  = v.addr;
      end else begin
         iValid = 1'b1;
         iAddr  = v.addr;
      end
      @(negedge clock);
      checkOutput($sformatf("vec%0d grant", idx), {62'd0, iReady, dReady}, v.isD ? 64'd1 : 64'd2);
      tick();
      iValid = 1'b0;
      dValid = 1'b0;
      @(negedge clock);
      checkOutput($sformatf("vec%0d m_valid", idx), {63'd0, mValid}, 64'd1);
      checkOutput($sformatf("vec%0d m_addr", idx), mAddr, v.addr);
      checkOutput($sformatf("vec%0d m_write", idx), {63'd0, mWrite}, {63'd0, v.expWrite});
      checkOutput($sformatf("vec%0d m_size", idx), {61'd0, mSize}, {61'd0, v.expSize});
      checkOutput($sformatf("vec%0d m_strobe", idx), {56'd0, mStrobe}, {56'd0, v.expStrobe});
      checkOutput($sformatf("vec%0d m_wdata", idx), mWdata, v.expWdata);
      repeat (v.k) tick();
      mAck   = 1'b1;
      mRdata = v.rdata;
      tick();
      mAck   = 1'b0;
      mRdata = ~v.rdata;
      @(negedge clock);
      checkOutput($sformatf("vec%0d resp valid", idx), {62'd0, iRespValid, dRespValid}, v.isD ? 64'd1 : 64'd2);
      if (v.isD) begin
         checkOutput($sformatf("vec%0d d_resp_data", idx), dRespData, v.expResp);
      end else begin
         checkOutput($sformatf("vec%0d i_resp_data", idx), {32'd0, iRespData}, {32'd0, v.expResp[31:0]});
      end
      checkOutput($sformatf("vec%0d m_valid in resp", idx), {63'd0, mValid}, 64'd0);
      tick();
      @(negedge clock);
      checkOutput($sformatf("vec%0d resp pulse end", idx), {62'd0, iRespValid, dRespValid}, 64'd0);
   endtask

   initial begin
      // isD addr write size strobe wdata k rdata | expSize expWrite expStrobe expWdata expResp
      vecs[0] = '{1'b0, 64'h0000_0000_8000_0000, 1'b1, 3'd3, 8'hFF, 64'h1111, 2,
                  64'h0000_0000_0013_0513, 3'd2, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0013_0513};
      vecs[1] = '{1'b1, 64'h0000_0000_0000_0100, 1'b0, 3'd3, 8'hFF, 64'h0, 0,
                  64'h1122_3344_5566_7788, 3'd3, 1'b0, 8'hFF, 64'h0, 64'h1122_3344_5566_7788};
      vecs[2] = '{1'b1, 64'h0000_0000_0000_0200, 1'b1, 3'd2, 8'h0F, 64'h0000_0000_DEAD_BEEF, 1,
                  64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 1'b1, 8'h0F, 64'h0000_0000_DEAD_BEEF, 64'h0};
      vecs[3] = '{1'b0, 64'h0000_0000_8000_0004, 1'b0, 3'd0, 8'h00, 64'h0, 0,
                  64'hAAAA_BBBB_CCCC_DDDD, 3'd2, 1'b0, 8'h00, 64'h0, 64'h0000_0000_CCCC_DDDD};
      vecs[4] = '{1'b0, 64'h0000_0000_8000_0008, 1'b1, 3'd1, 8'h3C, 64'h5A5A, 3,
                  64'h1234_5678_9ABC_DEF0, 3'd2, 1'b0, 8'h00, 64'h0, 64'h0000_0000_9ABC_DEF0};

      reset = 1'b1;
      iValid = 1'b0; iAddr = '0; iFlush = 1'b0;
      dValid = 1'b0; dAddr = '0; dWrite = 1'b0; dSize = '0; dStrobe = '0; dWdata = '0;
      mAck = 1'b0; mRdata = '0;

      // Reset values while reset is held.
      repeat (2) @(negedge clock);
      checkOutput("reset m_valid", {63'd0, mValid}, 64'd0);
      checkOutput("reset m_addr", mAddr, 64'd0);
      checkOutput("reset m_fields", {52'd0, mWrite, mSize, mStrobe}, 64'd0);
      checkOutput("reset ready", {62'd0, iReady, dReady}, 64'd0);
      checkOutput("reset resp", {62'd0, iRespValid, dRespValid}, 64'd0);
      checkOutput("reset resp data", dRespData | {32'd0, iRespData}, 64'd0);
      #1 reset = 1'b0;
      @(negedge clock);
      checkOutput("idle no request", {62'd0, iReady, dReady}, 64'd0);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Simultaneous I fetch and D store: D first, then I in the next IDLE.
      tick();
      iValid = 1'b1; iAddr = 64'h8000_0010;
      dValid = 1'b1; dAddr = 64'h100; dWrite = 1'b1; dSize = 3'd3; dStrobe = 8'hFF;
      dWdata = 64'h0000_0000_DEAD_BEEF;
      @(negedge clock);
      checkOutput("both valid grant", {62'd0, iReady, dReady}, 64'd1);
      tick();
      dValid = 1'b0;
      @(negedge clock);
      checkOutput("both store m_addr", mAddr, 64'h100);
      checkOutput("both store m_write", {63'd0, mWrite}, 64'd1);
      checkOutput("both store m_wdata", mWdata, 64'h0000_0000_DEAD_BEEF);
      checkOutput("both wait no ready", {62'd0, iReady, dReady}, 64'd0);
      mAck = 1'b1; mRdata = 64'h5555_5555_5555_5555;
      tick();
      mAck = 1'b0;
      @(negedge clock);
      checkOutput("both store resp", {62'd0, iRespValid, dRespValid}, 64'd1);
      checkOutput("both store resp data", dRespData, 64'd0);
      checkOutput("both resp no ready", {62'd0, iReady, dReady}, 64'd0);
      tick();
      @(negedge clock);
      checkOutput("both I after D", {62'd0, iReady, dReady}, 64'd2);
      tick();
      iValid = 1'b0;
      @(negedge clock);
      checkOutput("both I m_addr", mAddr, 64'h8000_0010);
      checkOutput("both I m_size", {61'd0, mSize}, 64'd2);
      mAck = 1'b1; mRdata = 64'hABCD_0000_0000_0093;
      tick();
      mAck = 1'b0;
      @(negedge clock);
      checkOutput("both I resp", {62'd0, iRespValid, dRespValid}, 64'd2);
      checkOutput("both I resp data", {32'd0, iRespData}, 64'h93);
      tick();
      @(negedge clock);
      checkOutput("both done", {62'd0, iRespValid, dRespValid}, 64'd0);

      // Flush during WAIT: transaction completes, response suppressed, D follows normally.
      tick();
      iValid = 1'b1; iAddr = 64'h8000_0020;
      @(negedge clock);
      checkOutput("flush grant", {62'd0, iReady, dReady}, 64'd2);
      tick();
      iValid = 1'b0; iFlush = 1'b1;
      @(negedge clock);
      checkOutput("flush m_valid", {63'd0, mValid}, 64'd1);
      tick();
      iFlush = 1'b0;
      @(negedge clock);
      checkOutput("flush m_valid held", {63'd0, mValid}, 64'd1);
      checkOutput("flush m_addr held", mAddr, 64'h8000_0020);
      mAck = 1'b1; mRdata = 64'h77;
      tick();
      mAck = 1'b0;
      @(negedge clock);
      checkOutput("flush resp suppressed", {62'd0, iRespValid, dRespValid}, 64'd0);
      checkOutput("flush resp data", {32'd0, iRespData}, 64'd0);
      applyStimulus(vecs[1], 10);

      // Both requesters saturated with immediate acks: strict priority or 4:1 with the guard.
      tick();
      iValid = 1'b1; iAddr = 64'h8000_0030;
      dValid = 1'b1; dAddr = 64'h180; dWrite = 1'b0; dSize = 3'd3; dStrobe = 8'hFF; dWdata = '0;
      mAck = 1'b1; mRdata = 64'h42;
      for (int t = 0; t < 10; t++) begin
         logic expI;
         expI = GUARD_ON && ((t % 5) == 4);
         @(negedge clock);
         checkOutput($sformatf("prio grant %0d", t), {62'd0, iReady, dReady}, expI ? 64'd2 : 64'd1);
         tick();
         if (t == 9) begin
            iValid = 1'b0;
            dValid = 1'b0;
         end
         @(negedge clock);
         checkOutput($sformatf("prio wait ready %0d", t), {62'd0, iReady, dReady}, 64'd0);
         tick();
         @(negedge clock);
         checkOutput($sformatf("prio resp %0d", t), {62'd0, iRespValid, dRespValid}, expI ? 64'd2 : 64'd1);
         tick();
      end
      mAck = 1'b0;
      @(negedge clock);
      checkOutput("prio idle", {62'd0, iReady, dReady}, 64'd0);

      // Asynchronous reset in the middle of WAIT.
      tick();
      iValid = 1'b1; iAddr = 64'h8000_0040;
      @(negedge clock);
      checkOutput("areset grant", {62'd0, iReady, dReady}, 64'd2);
      tick();
      iValid = 1'b0;
      @(negedge clock);
      checkOutput("areset pre m_valid", {63'd0, mValid}, 64'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("areset m_valid", {63'd0, mValid}, 64'd0);
      checkOutput("areset m_addr", mAddr, 64'd0);
      checkOutput("areset m_fields", {52'd0, mWrite, mSize, mStrobe}, 64'd0);
      checkOutput("areset resp", {62'd0, iRespValid, dRespValid}, 64'd0);
      #1 reset = 1'b0;
      applyStimulus(vecs[3], 20);

      // Long stall: fields frozen and no ready while both sides wait.
      tick();
      dValid = 1'b1; dAddr = 64'h300; dWrite = 1'b0; dSize = 3'd3; dStrobe = 8'hFF;
      dWdata = 64'h0123_4567_89AB_CDEF;
      @(negedge clock);
      checkOutput("stall grant", {62'd0, iReady, dReady}, 64'd1);
      tick();
      dAddr = 64'h400; dWrite = 1'b1; dStrobe = 8'h01; dWdata = 64'h9;
      iValid = 1'b1; iAddr = 64'h8000_0050;
      for (int c = 0; c < 50; c++) begin
         logic holdOk;
         @(negedge clock);
         holdOk = (mValid === 1'b1) && (mAddr === 64'h300) && (mWrite === 1'b0) &&
                  (mSize === 3'd3) && (mStrobe === 8'hFF) &&
                  (mWdata === 64'h0123_4567_89AB_CDEF) && (iReady === 1'b0) && (dReady === 1'b0);
         checkOutput($sformatf("stall hold %0d", c), {63'd0, holdOk}, 64'd1);
         tick();
      end
      iValid = 1'b0; dValid = 1'b0;
      mAck = 1'b1; mRdata = 64'hCAFE_F00D_0000_0001;
      tick();
      mAck = 1'b0;
      @(negedge clock);
      checkOutput("stall resp", {62'd0, iRespValid, dRespValid}, 64'd1);
      checkOutput("stall resp data", dRespData, 64'hCAFE_F00D_0000_0001);
      tick();
      @(negedge clock);
      checkOutput("stall done", {62'd0, iRespValid, dRespValid}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
